// File: rtl/cva6_axi_remap_pkg.sv
// Shared types for AXI ID remap tables (AR/R now, AW/B later).
package cva6_axi_remap_pkg;

  // Storage is sized for the widest configuration; narrower instances keep upper bits zero.
  localparam int unsigned MaxIdWidth  = 16;
  localparam int unsigned MaxCntWidth = 8;

  typedef struct packed {
    logic                   active;
    logic [MaxIdWidth-1:0]  in_id;
    logic [MaxCntWidth-1:0] count;
  } remap_entry_t;

  // Bits needed to count 0..max_txn outstanding transactions.
  function automatic int unsigned cnt_width(input int unsigned max_txn);
    return $clog2(max_txn + 1);
  endfunction

endpackage

// File: rtl/axi_id_remap_table.sv
// ID remap table: maps wide upstream IDs onto a small set of out IDs while outstanding.
module axi_id_remap_table
  import cva6_axi_remap_pkg::*;
#(
  parameter int unsigned InIdWidth   = 4,
  parameter int unsigned OutIdWidth  = 2,
  parameter int unsigned MaxTxnPerId = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [InIdWidth-1:0]  lookup_id_i,
  output logic [OutIdWidth-1:0] lookup_out_id_o,
  output logic                  lookup_stall_o,
  input  logic                  alloc_i,
  input  logic                  free_i,
  input  logic [OutIdWidth-1:0] free_id_i,
  output logic [InIdWidth-1:0]  restore_id_o,
  output logic                  busy_o
);

  localparam int unsigned NumEntries = 2 ** OutIdWidth;

  if (cnt_width(MaxTxnPerId) > MaxCntWidth || InIdWidth > MaxIdWidth) begin : g_width_chk
    $error("axi_id_remap_table: parameters exceed package storage widths");
  end

  remap_entry_t table_q [NumEntries];
  remap_entry_t table_d [NumEntries];

  logic [MaxIdWidth-1:0] lookup_ext;
  logic                  hit, free_found, free_legal, alloc_ok;
  logic [OutIdWidth-1:0] hit_idx, free_idx;

  assign lookup_ext   = MaxIdWidth'(lookup_id_i);
  assign restore_id_o = table_q[free_id_i].in_id[InIdWidth-1:0];
  assign free_legal   = free_i & table_q[free_id_i].active;
  assign alloc_ok     = alloc_i & ~lookup_stall_o;

  // Lookup: existing mapping for this ID first, else lowest-index free entry.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    busy_o     = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      if (!hit && table_q[i].active && table_q[i].in_id == lookup_ext) begin
        hit     = 1'b1;
        hit_idx = OutIdWidth'(i);
      end
      if (!free_found && !table_q[i].active) begin
        free_found = 1'b1;
        free_idx   = OutIdWidth'(i);
      end
      busy_o = busy_o | table_q[i].active;
    end
    lookup_out_id_o = hit ? hit_idx : free_idx;
    lookup_stall_o  = hit ? (table_q[hit_idx].count == MaxCntWidth'(MaxTxnPerId)) : ~free_found;
  end

  // Next state: allocate/increment on AR accept, decrement/free on R last; both cancel out.
  always_comb begin
    table_d = table_q;
    for (int i = 0; i < NumEntries; i++) begin
      if (alloc_ok && lookup_out_id_o == OutIdWidth'(i)
          && !(free_legal && free_id_i == OutIdWidth'(i))) begin
        if (table_q[i].active) begin
          table_d[i].count = table_q[i].count + MaxCntWidth'(1);
        end else begin
          table_d[i].active = 1'b1;
          table_d[i].in_id  = lookup_ext;
          table_d[i].count  = MaxCntWidth'(1);
        end
      end else if (free_legal && free_id_i == OutIdWidth'(i)
                   && !(alloc_ok && lookup_out_id_o == OutIdWidth'(i))) begin
        table_d[i].count = table_q[i].count - MaxCntWidth'(1);
        if (table_q[i].count == MaxCntWidth'(1)) begin
          table_d[i].active = 1'b0;
        end
      end
    end
  end

  // Table state register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NumEntries; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      table_q <= table_d;
    end
  end

  // A last beat for an unmapped out ID means downstream returned an ID never issued.
  assert property (@(posedge clock_i) disable iff (reset_i) free_i |-> table_q[free_id_i].active)
    else $error("axi_id_remap_table: R last to inactive entry %0d", free_id_i);

endmodule

// File: rtl/cva6_axi_rid_remap.sv
// AR/R ID remapper: narrows CVA6 read IDs for the system bus and restores them on R.
module cva6_axi_rid_remap
  import cva6_axi_remap_pkg::*;
#(
  parameter int unsigned InIdWidth   = 4,
  parameter int unsigned OutIdWidth  = 2,
  parameter int unsigned MaxTxnPerId = 4,
  parameter int unsigned ArPayloadW  = 64
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [InIdWidth-1:0]  s_ar_id_i,
  input  logic [ArPayloadW-1:0] s_ar_payload_i,
  input  logic                  s_ar_valid_i,
  output logic                  s_ar_ready_o,
  output logic [OutIdWidth-1:0] m_ar_id_o,
  output logic [ArPayloadW-1:0] m_ar_payload_o,
  output logic                  m_ar_valid_o,
  input  logic                  m_ar_ready_i,
  input  logic [OutIdWidth-1:0] m_r_id_i,
  input  logic                  m_r_last_i,
  input  logic                  m_r_valid_i,
  output logic                  m_r_ready_o,
  output logic [InIdWidth-1:0]  s_r_id_o,
  output logic                  s_r_valid_o,
  input  logic                  s_r_ready_i,
  output logic                  busy_o
);

  logic                  ar_valid_q, ar_valid_d;
  logic [OutIdWidth-1:0] ar_id_q, ar_id_d;
  logic [ArPayloadW-1:0] ar_payload_q, ar_payload_d;
  logic [OutIdWidth-1:0] lookup_out_id;
  logic                  stall, table_busy, ar_hs, r_last_hs;

  axi_id_remap_table #(
    .InIdWidth   (InIdWidth),
    .OutIdWidth  (OutIdWidth),
    .MaxTxnPerId (MaxTxnPerId)
  ) u_table (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .lookup_id_i     (s_ar_id_i),
    .lookup_out_id_o (lookup_out_id),
    .lookup_stall_o  (stall),
    .alloc_i         (ar_hs),
    .free_i          (r_last_hs),
    .free_id_i       (m_r_id_i),
    .restore_id_o    (s_r_id_o),
    .busy_o          (table_busy)
  );

  // Ready never looks at s_ar_valid_i, so upstream may wait for ready before asserting valid.
  assign s_ar_ready_o = (~ar_valid_q | m_ar_ready_i) & ~stall;
  assign ar_hs        = s_ar_valid_i & s_ar_ready_o;
  assign r_last_hs    = m_r_valid_i & s_r_ready_i & m_r_last_i;

  assign s_r_valid_o    = m_r_valid_i;
  assign m_r_ready_o    = s_r_ready_i;
  assign m_ar_valid_o   = ar_valid_q;
  assign m_ar_id_o      = ar_id_q;
  assign m_ar_payload_o = ar_payload_q;
  assign busy_o         = table_busy | ar_valid_q;

  // AR output register: load on accept, drain on downstream ready, otherwise hold.
  always_comb begin
    ar_valid_d   = ar_valid_q;
    ar_id_d      = ar_id_q;
    ar_payload_d = ar_payload_q;
    if (ar_hs) begin
      ar_valid_d   = 1'b1;
      ar_id_d      = lookup_out_id;
      ar_payload_d = s_ar_payload_i;
    end else if (m_ar_ready_i) begin
      ar_valid_d = 1'b0;
    end
  end

  // Control flops of the AR register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_id_q    <= ar_id_d;
    end
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clock_i) begin
    ar_payload_q <= ar_payload_d;
  end

endmodule

// File: tb/tb_cva6_axi_rid_remap.sv
// Bench for cva6_axi_rid_remap: directed scenarios plus random traffic against a slot model.
module tb_cva6_axi_rid_remap;

  localparam int MaxTxn = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_ar_id;
  logic [63:0] s_ar_payload;
  logic        s_ar_valid, s_ar_ready;
  logic [1:0]  m_ar_id;
  logic [63:0] m_ar_payload;
  logic        m_ar_valid, m_ar_ready;
  logic [1:0]  m_r_id;
  logic        m_r_last, m_r_valid, m_r_ready;
  logic [3:0]  s_r_id;
  logic        s_r_valid, s_r_ready;
  logic        busy;

  cva6_axi_rid_remap #(
    .InIdWidth   (4),
    .OutIdWidth  (2),
    .MaxTxnPerId (MaxTxn),
    .ArPayloadW  (64)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .s_ar_id_i      (s_ar_id),
    .s_ar_payload_i (s_ar_payload),
    .s_ar_valid_i   (s_ar_valid),
    .s_ar_ready_o   (s_ar_ready),
    .m_ar_id_o      (m_ar_id),
    .m_ar_payload_o (m_ar_payload),
    .m_ar_valid_o   (m_ar_valid),
    .m_ar_ready_i   (m_ar_ready),
    .m_r_id_i       (m_r_id),
    .m_r_last_i     (m_r_last),
    .m_r_valid_i    (m_r_valid),
    .m_r_ready_o    (m_r_ready),
    .s_r_id_o       (s_r_id),
    .s_r_valid_o    (s_r_valid),
    .s_r_ready_i    (s_r_ready),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per out-ID slot, which upstream ID owns it and how many reads are open.
  bit          slot_used [4];
  int          slot_owner [4];
  int          slot_open [4];
  bit          reg_full;
  int          reg_id;
  logic [63:0] reg_payload;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < 4; j++) begin
      slot_used[j]  = 1'b0;
      slot_owner[j] = 0;
      slot_open[j]  = 0;
    end
    reg_full = 1'b0;
  endtask

  // One clock: drive inputs at negedge, check outputs against the model, advance model at posedge.
  task automatic step(input bit r, input bit arv, input logic [3:0] arid, input logic [63:0] pl,
                      input bit mrdy, input bit rv, input logic [1:0] rid, input bit rl,
                      input bit srdy, output bit rdy_seen);
    int  owner_slot, free_slot, tgt;
    bit  blocked, exp_rdy, any_used, accept, retire;
    @(negedge clk);
    rst = r; s_ar_valid = arv; s_ar_id = arid; s_ar_payload = pl; m_ar_ready = mrdy;
    m_r_valid = rv; m_r_id = rid; m_r_last = rl; s_r_ready = srdy;
    #1;
    owner_slot = -1; free_slot = -1; any_used = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      if (slot_used[j] && slot_owner[j] == int'(arid)) owner_slot = j;
      if (!slot_used[j]) free_slot = j;
      any_used |= slot_used[j];
    end
    blocked = (owner_slot >= 0) ? (slot_open[owner_slot] == MaxTxn) : (free_slot < 0);
    exp_rdy = (!reg_full || mrdy) && !blocked;
    rdy_seen = s_ar_ready;
    check_eq("s_ar_ready", {63'd0, s_ar_ready}, {63'd0, exp_rdy});
    check_eq("busy", {63'd0, busy}, {63'd0, any_used || reg_full});
    check_eq("m_ar_valid", {63'd0, m_ar_valid}, {63'd0, reg_full});
    if (reg_full) begin
      check_eq("m_ar_id", 64'(m_ar_id), 64'(reg_id));
      check_eq("m_ar_payload", m_ar_payload, reg_payload);
    end
    check_eq("s_r_valid", {63'd0, s_r_valid}, {63'd0, rv});
    check_eq("m_r_ready", {63'd0, m_r_ready}, {63'd0, srdy});
    if (slot_used[rid]) check_eq("s_r_id", 64'(s_r_id), 64'(slot_owner[rid]));
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      tgt    = (owner_slot >= 0) ? owner_slot : free_slot;
      accept = arv && exp_rdy;
      retire = rv && srdy && rl && slot_used[rid];
      if (accept) begin
        slot_used[tgt]  = 1'b1;
        slot_owner[tgt] = int'(arid);
        slot_open[tgt]++;
        reg_full    = 1'b1;
        reg_id      = tgt;
        reg_payload = pl;
      end else if (mrdy) begin
        reg_full = 1'b0;
      end
      if (retire) begin
        slot_open[rid]--;
        if (slot_open[rid] == 0) slot_used[rid] = 1'b0;
      end
    end
  endtask

  task automatic ar(input logic [3:0] id, input bit mrdy, output bit rdy);
    step(1'b0, 1'b1, id, {$urandom, $urandom}, mrdy, 1'b0, 2'd0, 1'b0, 1'b1, rdy);
  endtask

  task automatic do_reset();
    bit unused_rdy;
    step(1'b1, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, unused_rdy);
  endtask

  initial begin
    bit          rdy, r, arv, mrdy, rv, rl, srdy;
    logic [3:0]  arid;
    logic [1:0]  rid;
    logic [63:0] pl;

    rst = 1'b1; s_ar_valid = 1'b0; s_ar_id = '0; s_ar_payload = '0; m_ar_ready = 1'b1;
    m_r_valid = 1'b0; m_r_id = '0; m_r_last = 1'b0; s_r_ready = 1'b1;
    repeat (2) @(posedge clk);
    model_clear();
    #1;
    check_eq("reset busy", {63'd0, busy}, 64'd0);
    check_eq("reset m_ar_valid", {63'd0, m_ar_valid}, 64'd0);

    // Two new IDs take out IDs 0 and 1; R on out ID 1 restores 4'h3.
    ar(4'hA, 1'b1, rdy);
    #1 check_eq("t1 first out id", 64'(m_ar_id), 64'd0);
    ar(4'h3, 1'b1, rdy);
    #1 check_eq("t1 second out id", 64'(m_ar_id), 64'd1);
    m_r_id = 2'd1;
    #1 check_eq("t1 restored id", 64'(s_r_id), 64'h3);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, rdy);

    // Same ID saturates its slot after MaxTxn reads.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ar(4'h5, 1'b1, rdy);
      check_eq($sformatf("t2 accept %0d", k), {63'd0, rdy}, {63'd0, k < MaxTxn});
    end
    step(1'b0, 1'b1, 4'h5, 64'd1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, rdy);
    check_eq("t2 stall during free", {63'd0, rdy}, 64'd0);
    ar(4'h5, 1'b1, rdy);
    check_eq("t2 accept after free", {63'd0, rdy}, 64'd1);

    // All slots busy; freeing slot 2 lets a new ID in on the following cycle.
    do_reset();
    for (int k = 1; k <= 4; k++) ar(4'(k), 1'b1, rdy);
    ar(4'h9, 1'b1, rdy);
    check_eq("t3 full stall", {63'd0, rdy}, 64'd0);
    step(1'b0, 1'b1, 4'h9, 64'd2, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, rdy);
    check_eq("t3 no same-cycle reuse", {63'd0, rdy}, 64'd0);
    ar(4'h9, 1'b1, rdy);
    check_eq("t3 accept", {63'd0, rdy}, 64'd1);
    #1 check_eq("t3 reused out id", 64'(m_ar_id), 64'd2);

    // Simultaneous AR accept and R last on the same slot leaves one read open.
    do_reset();
    ar(4'h7, 1'b1, rdy);
    step(1'b0, 1'b1, 4'h7, 64'd3, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, rdy);
    check_eq("t4 accept", {63'd0, rdy}, 64'd1);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, rdy);
    #1 check_eq("t4 still active", {63'd0, busy}, 64'd1);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, rdy);
    #1 check_eq("t4 freed", {63'd0, busy}, 64'd0);

    // Downstream backpressure holds the AR register and blocks upstream.
    do_reset();
    ar(4'h2, 1'b0, rdy);
    for (int k = 0; k < 5; k++) begin
      ar(4'h3, 1'b0, rdy);
      check_eq($sformatf("t5 blocked %0d", k), {63'd0, rdy}, 64'd0);
      #1 check_eq($sformatf("t5 held id %0d", k), 64'(m_ar_id), 64'd0);
    end
    ar(4'h3, 1'b1, rdy);
    check_eq("t5 released", {63'd0, rdy}, 64'd1);

    // Reset drops outstanding mappings.
    do_reset();
    for (int k = 1; k <= 3; k++) ar(4'(k), 1'b1, rdy);
    do_reset();
    #1 check_eq("t6 busy after reset", {63'd0, busy}, 64'd0);
    ar(4'hE, 1'b1, rdy);
    #1 check_eq("t6 out id after reset", 64'(m_ar_id), 64'd0);

    // Random traffic; R last only targets slots the model holds open.
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 299) == 0);
      arv  = ($urandom_range(0, 3) != 0);
      arid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      pl   = {$urandom, $urandom};
      mrdy = ($urandom_range(0, 3) != 0);
      rid  = 2'($urandom);
      rv   = ($urandom_range(0, 1) == 1);
      rl   = slot_used[rid] && ($urandom_range(0, 2) == 0);
      srdy = ($urandom_range(0, 3) != 0);
      step(r, arv, arid, pl, mrdy, rv, rid, rl, srdy, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
